// File: rtl/pf_iod_tx_clk_ctrl_if.sv
// Control and IOD-facing signal bundle for the forwarded-clock TX lane sequencer.
// All signals are level-sampled on the rising edge of FAB_CLK; there is no valid/ready
// handshake, and every input is treated as a steady level held for at least one clock.
interface pf_iod_tx_clk_ctrl_if;
  logic       EN;
  logic       PLL_LOCK;
  logic       CLK_INV;
  logic       TX_SYNC_RST;
  logic [3:0] TX_DATA_0;
  logic [1:0] OE_DATA_0;
  logic       TX_READY;
  logic       LOCK_LOST;
  logic [2:0] STATE;

  modport slave (
    input  EN, PLL_LOCK, CLK_INV,
    output TX_SYNC_RST, TX_DATA_0, OE_DATA_0, TX_READY, LOCK_LOST, STATE
  );

  modport master (
    output EN, PLL_LOCK, CLK_INV,
    input  TX_SYNC_RST, TX_DATA_0, OE_DATA_0, TX_READY, LOCK_LOST, STATE
  );
endinterface

// File: rtl/pf_iod_tx_clk_ctrl.sv
// Startup/run-time sequencer for a PolarFire IOD forwarded-clock TX lane (2:1 gearing).
// Lock filter -> TX_SYNC_RST pulse -> quiet-low settle -> continuous clock pattern.
module pf_iod_tx_clk_ctrl #(
  parameter int LOCK_FILTER   = 8,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 32,
  parameter int DRAIN_CYCLES  = 2,
  parameter int CNT_W         = 8
) (
  input  logic                  FAB_CLK,
  input  logic                  RESET_N,
  pf_iod_tx_clk_ctrl_if.slave   io
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_DRAIN    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_lost_q, lock_lost_d;
  logic             tx_sync_rst_q, tx_sync_rst_d;
  logic [3:0]       tx_data_q, tx_data_d;
  logic [1:0]       oe_data_q, oe_data_d;
  logic             tx_ready_q, tx_ready_d;

  // Next-state and shared phase counter. Lock loss outranks disable, which
  // outranks terminal count, in every non-IDLE state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      ST_IDLE: begin
        if (!io.EN) begin
          lock_lost_d = 1'b0;
        end
        if (io.EN && io.PLL_LOCK) begin
          if (cnt_q == LOCK_LAST) begin
            state_d = ST_RST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end

      ST_RST_HOLD: begin
        if (!io.PLL_LOCK) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end else if (!io.EN) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_SETTLE: begin
        if (!io.PLL_LOCK) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end else if (!io.EN) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        if (!io.PLL_LOCK) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end else if (!io.EN) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end

      ST_DRAIN: begin
        // EN is deliberately not looked at here: a drain always runs to completion.
        if (!io.PLL_LOCK) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pad outputs follow the registered state, so they lag STATE by one cycle.
  always_comb begin
    tx_sync_rst_d = 1'b1;
    tx_data_d     = 4'b0000;
    oe_data_d     = 2'b00;
    tx_ready_d    = 1'b0;

    case (state_q)
      ST_SETTLE, ST_DRAIN: begin
        tx_sync_rst_d = 1'b0;
        oe_data_d     = 2'b11;
      end
      ST_RUN: begin
        tx_sync_rst_d = 1'b0;
        oe_data_d     = 2'b11;
        tx_data_d     = io.CLK_INV ? 4'b1010 : 4'b0101;
        tx_ready_d    = 1'b1;
      end
      default: begin
        tx_sync_rst_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lock_lost_q   <= 1'b0;
      tx_sync_rst_q <= 1'b1;
      tx_data_q     <= 4'b0000;
      oe_data_q     <= 2'b00;
      tx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lock_lost_q   <= lock_lost_d;
      tx_sync_rst_q <= tx_sync_rst_d;
      tx_data_q     <= tx_data_d;
      oe_data_q     <= oe_data_d;
      tx_ready_q    <= tx_ready_d;
    end
  end

  assign io.STATE       = state_q;
  assign io.TX_SYNC_RST = tx_sync_rst_q;
  assign io.TX_DATA_0   = tx_data_q;
  assign io.OE_DATA_0   = oe_data_q;
  assign io.TX_READY    = tx_ready_q;
  assign io.LOCK_LOST   = lock_lost_q;

endmodule

// File: doc/pf_iod_tx_clk_ctrl.md
Name: pf_iod_tx_clk_ctrl

Overview:
- Startup and run-time sequencer for a PolarFire IOD forwarded-clock TX lane in 2:1 gearing: 4-bit TX_DATA word and 2-bit OE word per FAB_CLK.
- Waits for a filtered PLL lock, then pulses the lane's TX_SYNC_RST and settles the pad at a quiet low.
- Then drives the continuous forwarded-clock pattern.
- Handles orderly disable (drain) and abrupt PLL lock loss.

Parameters:
- LOCK_FILTER, 8: consecutive PLL_LOCK=1 cycles required before leaving IDLE (1..255).
- RST_CYCLES, 16: cycles TX_SYNC_RST is held in RST_HOLD (1..255).
- SETTLE_CYCLES, 32: cycles of quiet-low output with OE enabled before RUN (1..255).
- DRAIN_CYCLES, 2: quiet-low cycles before OE release on disable (1..255).
- CNT_W, 8: width of the shared phase counter.

Ports:
- FAB_CLK  in  1  fabric clock; all logic rising-edge.
- RESET_N  in  1  synchronous, active-low reset.
- EN  in  1  lane enable from the fabric control block.
- PLL_LOCK  in  1  lock from the HS_IO_CLK source PLL; synchronised upstream.
- CLK_INV  in  1  0: pattern 4'b0101; 1: pattern 4'b1010 (bit0 transmitted first).
- TX_SYNC_RST  out  1  to IOD TX_SYNC_RST.
- TX_DATA_0  out  4  to IOD TX_DATA_0.
- OE_DATA_0  out  2  to IOD OE_DATA_0.
- TX_READY  out  1  high while in RUN.
- LOCK_LOST  out  1  sticky lock-loss flag.
- STATE  out  3  encoding: IDLE=0, RST_HOLD=1, SETTLE=2, RUN=3, DRAIN=4.

Behaviour:
- Clocking and reset:
  - Single clock FAB_CLK; reset RESET_N synchronous, active-low.
  - All outputs registered.
- Reset values: STATE=IDLE, TX_SYNC_RST=1, TX_DATA_0=4'b0000, OE_DATA_0=2'b00, TX_READY=0, LOCK_LOST=0, counters=0.
- Output mapping per state, visible on the cycle after the state register updates:
  - IDLE/RST_HOLD: TX_SYNC_RST=1, OE=00, DATA=0000.
  - SETTLE: TX_SYNC_RST=0, OE=11, DATA=0000.
  - RUN: TX_SYNC_RST=0, OE=11, DATA=pattern(CLK_INV), TX_READY=1.
  - DRAIN: TX_SYNC_RST=0, OE=11, DATA=0000.
- IDLE:
  - Filter counter increments while EN=1 and PLL_LOCK=1; it clears on any cycle where either is 0.
  - When the count reaches LOCK_FILTER, go to RST_HOLD and clear the counter.
- RST_HOLD: counter runs 0..RST_CYCLES-1, then go to SETTLE.
- SETTLE: counter runs 0..SETTLE_CYCLES-1, then go to RUN.
- RUN: stay indefinitely. A CLK_INV change appears on TX_DATA_0 exactly one cycle later, with no gap word.
- Disable:
  - EN=0 in RST_HOLD, SETTLE or RUN goes to DRAIN.
  - DRAIN counts DRAIN_CYCLES, then goes to IDLE.
  - EN re-asserted during DRAIN is ignored; the sequence completes and restarts from the IDLE filter.
- Lock loss:
  - PLL_LOCK=0 in any non-IDLE state goes to IDLE next cycle, skipping DRAIN.
  - LOCK_LOST is set on that cycle.
  - Lock loss has priority over EN=0 and over counter terminal count when simultaneous.
- LOCK_LOST:
  - Stays set until RESET_N=0, or EN=0 while in IDLE.
  - Does not block restart.
- Counter terminal values are compared as CNT_W-bit unsigned values; no wrap occurs because parameters are ≤255.
- Total latency from lock-filter satisfied to TX_READY=1: RST_CYCLES+SETTLE_CYCLES+1 cycles.
- Reset asserted mid-operation: next cycle all outputs take their reset values regardless of state.

Test Plan:
- Nominal startup:
  - Stimulus: reset 4 cycles, then EN=1, PLL_LOCK=1 held.
  - Required: TX_SYNC_RST high through cycle 8+16.
  - Required: OE=11 with DATA=0000 for 32 cycles.
  - Required: then DATA=0101 and TX_READY=1 at cycle 8+16+32+1.
- Lock filter glitch:
  - Stimulus: PLL_LOCK high 7 cycles, low 1, then high.
  - Required: the counter restarts; RST_HOLD is entered only after 8 further consecutive high cycles.
- CLK_INV toggle in RUN:
  - Stimulus: CLK_INV 0→1 at cycle N.
  - Required: DATA=0101 at N, 1010 at N+1, with no 0000 word between.
- Disable in RUN:
  - Stimulus: EN=0 for 1 cycle.
  - Required: TX_READY=0 the next cycle; DATA=0000, OE=11 for 2 cycles; then OE=00, TX_SYNC_RST=1, STATE=0; LOCK_LOST stays 0.
- Lock loss, simultaneous with disable:
  - Stimulus: PLL_LOCK=0 and EN=0 on the same cycle in SETTLE.
  - Required: STATE goes straight to IDLE (no DRAIN), LOCK_LOST=1, OE=00.
  - Required: LOCK_LOST clears only once EN=0 is seen in IDLE.
- Reset mid-RUN:
  - Stimulus: RESET_N=0 for 1 cycle during RUN.
  - Required: next cycle TX_SYNC_RST=1, DATA=0000, OE=00, TX_READY=0, STATE=0.
